// File: rtl/if_id_queue.sv
// IF/ID decoupling stage: DEPTH-entry fetch queue feeding the ID output register.
// Ports: clk, rst (async, active-low), flush/clrslot control, IF valid/ready push side, ID outputs, q_count.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int EW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   clrslot,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [AW-1:0]          if_pc,
  input  logic [AW-1:0]          if_pcp4,
  input  logic [DW-1:0]          if_inst,
  input  logic [EW-1:0]          if_excp,
  input  logic                   id_stall,
  input  logic                   id_isbranch,
  output logic [AW-1:0]          id_pc,
  output logic [AW-1:0]          id_pcp4,
  output logic [DW-1:0]          id_inst,
  output logic [EW-1:0]          id_excp,
  output logic                   id_inslot,
  output logic                   id_null,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pcp4;
    logic [DW-1:0] inst;
    logic [EW-1:0] excp;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t        mem [DEPTH];
  entry_t        if_e;
  entry_t        head_e;
  entry_t        sel_e;
  entry_t        out_q;
  entry_t        out_d;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          null_q;
  logic          null_d;
  logic          slot_q;
  logic          slot_d;
  logic          sp_q;
  logic          sp_d;
  logic          kp_q;
  logic          kp_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          adv;
  logic          avail;
  logic          take;
  logic          kill;
  logic          pop;
  logic          byp;
  logic          wr_en;
  logic          slot_take;

  assign if_e = '{
    pc:   if_pc,
    pcp4: if_pcp4,
    inst: if_inst,
    excp: if_excp
  };

  assign head_e = mem[rd_ptr];

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_C);
  assign if_ready = ~full & ~flush;
  assign push     = if_valid & if_ready;
  assign adv      = ~id_stall;

  // A real entry is available from the head, or by bypass when empty.
  assign avail = ~empty | push;
  assign take  = adv & avail;
  assign kill  = take & (clrslot | kp_q);
  assign pop   = adv & ~empty;
  assign byp   = adv & empty & push;
  assign wr_en = push & ~byp;
  assign sel_e = empty ? if_e : head_e;

  // The next real entry is a delay slot if a live branch is leaving ID
  // now, or one left earlier while only bubbles followed it.
  assign slot_take = (~null_q & id_isbranch) | sp_q;

  always_comb begin
    rd_d   = rd_ptr;
    wr_d   = wr_ptr;
    cnt_d  = cnt_q;
    out_d  = out_q;
    null_d = null_q;
    slot_d = slot_q;
    sp_d   = sp_q;
    kp_d   = kp_q;
    if (flush) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      out_d  = BUBBLE;
      null_d = 1'b1;
      slot_d = 1'b0;
      sp_d   = 1'b0;
      kp_d   = 1'b0;
    end else if (adv) begin
      rd_d  = rd_ptr + PW'(pop);
      wr_d  = wr_ptr + PW'(wr_en);
      cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
      if (kill) begin
        out_d  = BUBBLE;
        null_d = 1'b1;
        slot_d = 1'b0;
        sp_d   = 1'b0;
        kp_d   = 1'b0;
      end else if (take) begin
        out_d  = sel_e;
        null_d = 1'b0;
        slot_d = slot_take;
        sp_d   = 1'b0;
      end else begin
        out_d  = BUBBLE;
        null_d = 1'b1;
        slot_d = 1'b0;
        if (clrslot) begin
          kp_d = 1'b1;
          sp_d = 1'b0;
        end else if (!kp_q) begin
          sp_d = slot_take;
        end
      end
    end else begin
      wr_d  = wr_ptr + PW'(wr_en);
      cnt_d = cnt_q + CW'(wr_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      out_q  <= BUBBLE;
      null_q <= 1'b1;
      slot_q <= 1'b0;
      sp_q   <= 1'b0;
      kp_q   <= 1'b0;
    end else begin
      rd_ptr <= rd_d;
      wr_ptr <= wr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      null_q <= null_d;
      slot_q <= slot_d;
      sp_q   <= sp_d;
      kp_q   <= kp_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= if_e;
    end
  end

  assign id_pc     = out_q.pc;
  assign id_pcp4   = out_q.pcp4;
  assign id_inst   = out_q.inst;
  assign id_excp   = out_q.excp;
  assign id_inslot = slot_q;
  assign id_null   = null_q;
  assign q_count   = cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: bypass, fill/drain, delay slot,
// clrslot squash, flush and asynchronous reset.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        clrslot;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pcp4;
  logic [31:0] if_inst;
  logic [4:0]  if_excp;
  logic        id_stall;
  logic        id_isbranch;
  logic [31:0] id_pc;
  logic [31:0] id_pcp4;
  logic [31:0] id_inst;
  logic [4:0]  id_excp;
  logic        id_inslot;
  logic        id_null;
  logic [2:0]  q_count;

  int vecs;
  int errs;

  if_id_queue #(
    .DEPTH(4),
    .AW(32),
    .DW(32),
    .EW(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .clrslot(clrslot),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_pcp4(if_pcp4),
    .if_inst(if_inst),
    .if_excp(if_excp),
    .id_stall(id_stall),
    .id_isbranch(id_isbranch),
    .id_pc(id_pc),
    .id_pcp4(id_pcp4),
    .id_inst(id_inst),
    .id_excp(id_excp),
    .id_inslot(id_inslot),
    .id_null(id_null),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_pcp4  = pc + 32'd4;
    if_inst  = pc ^ 32'hA5A5_0000;
    if_excp  = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    clrslot = 1'b0;
    id_stall = 1'b0;
    id_isbranch = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL rst_null got %b exp 1", id_null); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL rst_pc got %h exp 0", id_pc); end
    vecs++; if (id_inst !== 32'h0) begin errs++; $display("FAIL rst_inst got %h exp 0", id_inst); end
    vecs++; if (id_inslot !== 1'b0) begin errs++; $display("FAIL rst_inslot got %b exp 0", id_inslot); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", q_count); end
    rst = 1'b1;
    #1;
    vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", if_ready); end
  endtask

  task automatic test_bypass();
    if_valid = 1'b1;
    if_pc    = 32'h1000;
    if_pcp4  = 32'h1004;
    if_inst  = 32'h2401_0001;
    if_excp  = 5'd0;
    tick();
    vecs++; if (id_pc !== 32'h1000) begin errs++; $display("FAIL byp_pc got %h exp 1000", id_pc); end
    vecs++; if (id_pcp4 !== 32'h1004) begin errs++; $display("FAIL byp_pcp4 got %h exp 1004", id_pcp4); end
    vecs++; if (id_inst !== 32'h2401_0001) begin errs++; $display("FAIL byp_inst got %h exp 24010001", id_inst); end
    vecs++; if (id_null !== 1'b0) begin errs++; $display("FAIL byp_null got %b exp 0", id_null); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL byp_count got %0d exp 0", q_count); end
    drive(1'b0, 32'h0);
    tick();
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL byp_bubble got %b exp 1", id_null); end
  endtask

  task automatic test_stall_fill();
    logic [2:0]  exp_cnt;
    logic [31:0] exp_pc;
    id_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h1100 + 32'(4 * i));
      vecs++; if (if_ready !== (i < 4)) begin errs++; $display("FAIL fill_ready%0d got %b exp %b", i, if_ready, (i < 4)); end
      tick();
    end
    vecs++; if (q_count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d exp 4", q_count); end
    vecs++; if (if_ready !== 1'b0) begin errs++; $display("FAIL fill_full got %b exp 0", if_ready); end
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL fill_hold got %b exp 1", id_null); end
    drive(1'b0, 32'h0);
    id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc  = 32'h1100 + 32'(4 * i);
      exp_cnt = 3'(3 - i);
      vecs++; if (id_pc !== exp_pc) begin errs++; $display("FAIL drain_pc%0d got %h exp %h", i, id_pc, exp_pc); end
      vecs++; if (id_null !== 1'b0) begin errs++; $display("FAIL drain_null%0d got %b exp 0", i, id_null); end
      vecs++; if (q_count !== exp_cnt) begin errs++; $display("FAIL drain_cnt%0d got %0d exp %0d", i, q_count, exp_cnt); end
      vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL drain_ready%0d got %b exp 1", i, if_ready); end
    end
    tick();
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL drain_end got %b exp 1", id_null); end
  endtask

  task automatic test_delay_slot();
    drive(1'b1, 32'h2000);
    tick();
    vecs++; if (id_pc !== 32'h2000) begin errs++; $display("FAIL ds_br got %h exp 2000", id_pc); end
    drive(1'b0, 32'h0);
    id_isbranch = 1'b1;
    tick();
    id_isbranch = 1'b0;
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL ds_b1null got %b exp 1", id_null); end
    vecs++; if (id_inslot !== 1'b0) begin errs++; $display("FAIL ds_b1slot got %b exp 0", id_inslot); end
    tick();
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL ds_b2null got %b exp 1", id_null); end
    vecs++; if (id_inslot !== 1'b0) begin errs++; $display("FAIL ds_b2slot got %b exp 0", id_inslot); end
    drive(1'b1, 32'h2004);
    tick();
    vecs++; if (id_pc !== 32'h2004) begin errs++; $display("FAIL ds_pc got %h exp 2004", id_pc); end
    vecs++; if (id_inslot !== 1'b1) begin errs++; $display("FAIL ds_slot got %b exp 1", id_inslot); end
    drive(1'b1, 32'h2008);
    tick();
    vecs++; if (id_pc !== 32'h2008) begin errs++; $display("FAIL ds_next got %h exp 2008", id_pc); end
    vecs++; if (id_inslot !== 1'b0) begin errs++; $display("FAIL ds_noslot got %b exp 0", id_inslot); end
    drive(1'b0, 32'h0);
    tick();
  endtask

  task automatic test_clrslot();
    drive(1'b1, 32'h3000);
    tick();
    id_stall = 1'b1;
    drive(1'b1, 32'h3004);
    tick();
    drive(1'b1, 32'h3008);
    tick();
    vecs++; if (q_count !== 3'd2) begin errs++; $display("FAIL clr_cnt got %0d exp 2", q_count); end
    vecs++; if (id_pc !== 32'h3000) begin errs++; $display("FAIL clr_br got %h exp 3000", id_pc); end
    drive(1'b0, 32'h0);
    id_stall = 1'b0;
    id_isbranch = 1'b1;
    clrslot = 1'b1;
    tick();
    id_isbranch = 1'b0;
    clrslot = 1'b0;
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL clr_null got %b exp 1", id_null); end
    vecs++; if (q_count !== 3'd1) begin errs++; $display("FAIL clr_cnt1 got %0d exp 1", q_count); end
    tick();
    vecs++; if (id_pc !== 32'h3008) begin errs++; $display("FAIL clr_pc got %h exp 3008", id_pc); end
    vecs++; if (id_inslot !== 1'b0) begin errs++; $display("FAIL clr_slot got %b exp 0", id_inslot); end
    vecs++; if (id_null !== 1'b0) begin errs++; $display("FAIL clr_real got %b exp 0", id_null); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h3FFC);
    tick();
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i));
      tick();
    end
    vecs++; if (q_count !== 3'd3) begin errs++; $display("FAIL fl_cnt3 got %0d exp 3", q_count); end
    vecs++; if (id_pc !== 32'h3FFC) begin errs++; $display("FAIL fl_hold got %h exp 3ffc", id_pc); end
    drive(1'b1, 32'h4100);
    flush = 1'b1;
    #1;
    vecs++; if (if_ready !== 1'b0) begin errs++; $display("FAIL fl_ready got %b exp 0", if_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    id_stall = 1'b0;
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL fl_null got %b exp 1", id_null); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL fl_pc got %h exp 0", id_pc); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL fl_cnt got %0d exp 0", q_count); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL fl_stale%0d pc %h null %b exp bubble", i, id_pc, id_null); end
    end
  endtask

  task automatic test_async_reset();
    id_stall = 1'b1;
    drive(1'b1, 32'h5000);
    tick();
    drive(1'b1, 32'h5004);
    tick();
    id_stall = 1'b0;
    drive(1'b1, 32'h5008);
    tick();
    vecs++; if (id_pc !== 32'h5000) begin errs++; $display("FAIL ar_pre got %h exp 5000", id_pc); end
    #2;
    rst = 1'b0;
    #1;
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL ar_null got %b exp 1", id_null); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL ar_pc got %h exp 0", id_pc); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL ar_cnt got %0d exp 0", q_count); end
    drive(1'b0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL ar_ready got %b exp 1", if_ready); end
    tick();
    vecs++; if (id_null !== 1'b1) begin errs++; $display("FAIL ar_lost got %b exp 1", id_null); end
    vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL ar_cnt2 got %0d exp 0", q_count); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_bypass();
    test_stall_fill();
    test_delay_slot();
    test_clrslot();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
